// File: rtl/adder_share_arbiter_pkg.sv
// adder_share_arbiter_pkg
//   Shared constants, FSM state type and helpers for the shared-adder arbiter.
//   ADD_W  : operand width of the shared adder
//   SUM_W  : result width {cout, S}
//   CNT_W  : settle counter width (SETTLE_CYCLES up to 15)
package adder_share_arbiter_pkg;

   localparam int ADD_W = 6;
   localparam int SUM_W = 7;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   // Round-robin successor of idx among n requesters.
   function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if
//   Request/response bundle between client blocks and the shared adder.
//   req_valid/req_ready : per-requester handshake (N_REQ bits)
//   req_x/req_y         : packed operands, slice i = [6i+5:6i]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_sum      : granted requester index and {cout, S}
//   busy                : arbiter not idle
//   master = client side, slave = arbiter side
interface adder_share_arbiter_if
   import adder_share_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
);
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [ADD_W*N_REQ-1:0] req_x;
   logic [ADD_W*N_REQ-1:0] req_y;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [SUM_W-1:0]       rsp_sum;
   logic                   busy;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, busy
   );
endinterface

// File: rtl/adder.sv
// adder
//   6-bit gate-level ripple-carry adder, no carry-in.
//   X, Y : operands
//   S    : sum bits
//   cout : carry out of bit 5
module adder (
   input  logic [5:0] X,
   input  logic [5:0] Y,
   output logic [5:0] S,
   output logic       cout
);
   logic [6:0] c;
   logic [5:0] p;
   logic [5:0] g;
   logic [5:0] t;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < 6; i++) begin : g_bit
      xor u_p (p[i], X[i], Y[i]);
      xor u_s (S[i], p[i], c[i]);
      and u_g (g[i], X[i], Y[i]);
      and u_t (t[i], p[i], c[i]);
      or  u_c (c[i+1], g[i], t[i]);
   end

   assign cout = c[6];
endmodule

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter: grants the first asserted req at or
//   after ptr, searching upward with wrap-around.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot grant (zero when no request)
//   idx   : encoded grant index (zero when no request)
//   any   : at least one request present
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         int unsigned cand;
         cand = (32'(ptr) + k) % N_REQ;
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares one 6-bit adder among N_REQ requesters. A round-robin grant in IDLE
//   latches the winner's operands, which are held on the adder for
//   SETTLE_CYCLES before {cout, S} is captured and offered on the response
//   port until accepted.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of adder_share_arbiter_if (requests, response, busy)
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int ID_W          = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   adder_share_arbiter_if.slave bus
);
   arb_state_t       state_q;
   arb_state_t       state_d;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [ID_W-1:0]  id_q;
   logic [CNT_W-1:0] cnt_q;
   logic [ADD_W-1:0] op_x_q;
   logic [ADD_W-1:0] op_y_q;
   logic             rsp_valid_q;
   logic [ID_W-1:0]  rsp_id_q;
   logic [SUM_W-1:0] rsp_sum_q;

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_any;
   logic [ADD_W-1:0] sel_x;
   logic [ADD_W-1:0] sel_y;
   logic [ADD_W-1:0] add_s;
   logic             add_cout;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (ID_W)
   ) u_rr_arbiter (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   adder u_adder (
      .X    (op_x_q),
      .Y    (op_y_q),
      .S    (add_s),
      .cout (add_cout)
   );

   // One-hot grant drives an AND-OR operand mux.
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_x = sel_x | bus.req_x[i*ADD_W +: ADD_W];
            sel_y = sel_y | bus.req_y[i*ADD_W +: ADD_W];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant_any)       state_d = SETTLE;
         SETTLE:  if (cnt_q == '0)     state_d = RESP;
         RESP:    if (bus.rsp_ready)   state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Outputs; req_ready is forced low while rst is held so that the async
   // reset clears it even though it is combinational from req_valid.
   always_comb begin
      bus.req_ready = '0;
      if (state_q == IDLE && !rst) bus.req_ready = grant;
      bus.busy      = (state_q != IDLE);
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         op_x_q      <= '0;
         op_y_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (grant_any) begin
                  op_x_q   <= sel_x;
                  op_y_q   <= sel_y;
                  id_q     <= grant_idx;
                  cnt_q    <= CNT_W'(SETTLE_CYCLES - 1);
                  rr_ptr_q <= ID_W'(next_index(32'(grant_idx), N_REQ));
               end
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  rsp_sum_q   <= {add_cout, add_s};
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) rsp_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter
//   Directed bench for adder_share_arbiter (N_REQ=4, ID_W=2, SETTLE_CYCLES=2).
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_adder_share_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   adder_share_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

   adder_share_arbiter #(
      .N_REQ         (4),
      .ID_W          (2),
      .SETTLE_CYCLES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [6:0] add7(input logic [5:0] x, input logic [5:0] y);
      return {1'b0, x} + {1'b0, y};
   endfunction

   task automatic set_ops(input int r, input logic [5:0] x, input logic [5:0] y);
      bus.req_x[6*r +: 6] = x;
      bus.req_y[6*r +: 6] = y;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Wait (bounded) for rsp_valid, then check id and sum.
   task automatic wait_rsp(input string tag, input logic [1:0] exp_id, input logic [6:0] exp_sum);
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_valid"}, bus.rsp_valid, 1);
      check({tag, "_id"},    bus.rsp_id,    exp_id);
      check({tag, "_sum"},   bus.rsp_sum,   exp_sum);
   endtask

   // One request on requester r with rsp_ready high; checks grant, latency,
   // id and sum.
   task automatic single(input int r, input logic [5:0] x, input logic [5:0] y,
                         input logic [6:0] exp_sum, input string tag);
      int n;
      @(negedge clk);
      set_ops(r, x, y);
      bus.req_valid[r] = 1'b1;
      #1;
      n = 0;
      while (!bus.req_ready[r] && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_grant"}, bus.req_ready, 32'(1) << r);
      @(negedge clk);
      bus.req_valid[r] = 1'b0;
      #1;
      n = 1;
      while (!bus.rsp_valid && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, n, 3);
      check({tag, "_id"},  bus.rsp_id,  r);
      check({tag, "_sum"}, bus.rsp_sum, exp_sum);
   endtask

   initial begin
      int exp_order [5] = '{0, 1, 2, 3, 0};
      int n_grant;
      int n_rsp;
      int cyc;
      logic [5:0] rx [4];
      logic [5:0] ry [4];

      rst           = 1'b1;
      bus.req_valid = 4'hF;
      bus.req_x     = '0;
      bus.req_y     = '0;
      bus.rsp_ready = 1'b1;

      // Reset state, with every request asserted to show req_ready is held low.
      @(negedge clk); #1;
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_busy",      bus.busy,      0);
      check("rst_rsp_id",    bus.rsp_id,    0);
      check("rst_rsp_sum",   bus.rsp_sum,   0);
      bus.req_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // Basic adds and overflow.
      single(0, 6'd5,  6'd9,  7'd14,        "single");
      single(0, 6'd63, 6'd1,  7'b1000000,   "ovf1");
      single(2, 6'd63, 6'd63, 7'b1111110,   "ovf2");

      // Round robin with all four requesters held valid.
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         rx[i] = 6'(10 + 7 * i);
         ry[i] = 6'(40 + 5 * i);
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) set_ops(i, rx[i], ry[i]);
      bus.req_valid = 4'hF;
      n_grant = 0;
      n_rsp   = 0;
      cyc     = 0;
      while (n_rsp < 5 && cyc < 80) begin
         #1;
         if (bus.req_ready != 0) begin
            if (n_grant < 5) check("rr_grant", bus.req_ready, 32'(1) << exp_order[n_grant]);
            n_grant++;
         end
         if (bus.rsp_valid) begin
            check("rr_id",  bus.rsp_id,  exp_order[n_rsp]);
            check("rr_sum", bus.rsp_sum, add7(rx[exp_order[n_rsp]], ry[exp_order[n_rsp]]));
            n_rsp++;
            if (n_rsp == 5) bus.req_valid = '0;
         end
         if (n_rsp < 5) begin
            @(negedge clk);
            cyc++;
         end
      end
      check("rr_count", n_rsp, 5);

      // Backpressure: response held for 10 cycles while another request waits.
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      set_ops(3, 6'd20, 6'd22);
      bus.req_valid[3] = 1'b1;
      #1;
      check("bp_grant", bus.req_ready, 4'b1000);
      @(negedge clk);
      bus.req_valid[3] = 1'b0;
      #1;
      wait_rsp("bp_first", 2'd3, 7'd42);
      bus.req_valid[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         check("bp_hold_valid", bus.rsp_valid, 1);
         check("bp_hold_sum",   bus.rsp_sum,   42);
         check("bp_hold_ready", bus.req_ready, 0);
      end
      @(negedge clk);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_pre_release", bus.rsp_valid, 1);
      @(negedge clk); #1;
      check("bp_released", bus.rsp_valid, 0);
      check("bp_idle",     bus.busy,      0);

      // Reset mid-SETTLE with requester 2 in flight.
      @(negedge clk);
      set_ops(2, 6'd17, 6'd30);
      set_ops(0, 6'd1,  6'd2);
      bus.req_valid[2] = 1'b1;
      #1;
      check("mid_grant", bus.req_ready, 4'b0100);
      @(negedge clk);
      #1;
      check("mid_busy", bus.busy, 1);
      bus.req_valid = 4'b0101;
      rst = 1'b1;
      #1;
      check("mid_rst_busy",      bus.busy,      0);
      check("mid_rst_ready",     bus.req_ready, 0);
      check("mid_rst_rsp_valid", bus.rsp_valid, 0);
      check("mid_rst_rsp_sum",   bus.rsp_sum,   0);
      check("mid_rst_rsp_id",    bus.rsp_id,    0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("mid_rst_hold", bus.rsp_valid, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_after_grant", bus.req_ready, 4'b0001);
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      wait_rsp("mid_after", 2'd0, 7'd3);

      // Exhaustive operand sweep through requester 1.
      for (int x = 0; x < 64; x++) begin
         for (int y = 0; y < 64; y++) begin
            single(1, 6'(x), 6'(y), 7'(x + y), "exh");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
